// File: rtl/kgp_pkg.sv
// Shared KGP-RISC datapath constants and the writeback decode helper.
package kgp_pkg;

  localparam logic [2:0] OP_ALU       = 3'd0;
  localparam logic [2:0] OP_SHIFT_IMM = 3'd1;
  localparam logic [2:0] OP_MEM       = 3'd2;
  localparam logic [2:0] OP_BRANCH    = 3'd3;

  localparam logic [3:0] FC_LW = 4'd0;
  localparam logic [3:0] FC_BL = 4'd9;

  localparam int LINK_REG_DEFAULT = 31;

  typedef enum logic [1:0] {
    WK_NONE,
    WK_ALU,
    WK_LINK,
    WK_LOAD
  } wr_kind_e;

  // Classify a retiring instruction by what it does to the register file.
  function automatic wr_kind_e decode_kind(input logic [2:0] op, input logic [3:0] fc);
    wr_kind_e k;
    k = WK_NONE;
    case (op)
      OP_ALU, OP_SHIFT_IMM: k = WK_ALU;
      OP_BRANCH:            k = (fc == FC_BL) ? WK_LINK : WK_NONE;
      OP_MEM:               k = (fc == FC_LW) ? WK_LOAD : WK_NONE;
      default:              k = WK_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/wb_commit_unit_pend_queue.sv
// In-order FIFO of outstanding load destinations with per-entry valid bits
// and a parallel address-match port for hazard checks.
module pend_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_match
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0]         hit;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic                     push_ok, pop_ok;

  // Self-guarding so a misbehaving parent cannot corrupt pointers.
  assign push_ok = push && (count != FULL);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        addr_q[wr_ptr] <= push_addr;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_addr = addr_q[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign hit[g] = vld_q[g] && (addr_q[g] == chk_addr);
  end

  assign chk_match = |hit;

endmodule

// File: rtl/wb_commit_unit.sv
// Registered writeback/commit stage: ALU/link writes on accept, deferred
// load writes on memory return, with an in-order pending-load queue.
module wb_commit_unit
  import kgp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int LINK_REG   = LINK_REG_DEFAULT,
  parameter int PEND_DEPTH = 4,
  parameter int ZERO_WIRED = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  opcode,
  input  logic [3:0]                  fcode,
  input  logic [RADDR_W-1:0]          rs_addr,
  input  logic [DATA_W-1:0]           alu_out,
  input  logic [DATA_W-1:0]           ra,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        reg_write,
  output logic [RADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  input  logic [RADDR_W-1:0]          chk_addr,
  output logic                        chk_pending,
  output logic [$clog2(PEND_DEPTH):0] pend_count,
  output logic                        underflow_err
);

  localparam int CW = $clog2(PEND_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(PEND_DEPTH);

  typedef struct packed {
    logic               en;
    logic [RADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
  } wr_t;

  wr_t                nxt;
  wr_kind_e           kind;
  logic               accept, push, pop, q_empty, q_match;
  logic [RADDR_W-1:0] head_addr;

  assign q_empty  = (pend_count == '0);
  // A returning load owns the write port, so every opcode stalls behind it.
  assign in_ready = !mem_rvalid && (pend_count < FULL);
  assign accept   = in_valid && in_ready;
  assign kind     = decode_kind(opcode, fcode);
  assign pop      = mem_rvalid && !q_empty;

  always_comb begin
    nxt  = '0;
    push = 1'b0;
    if (mem_rvalid) begin
      if (!q_empty) nxt = '{1'b1, head_addr, mem_rdata};
    end else if (accept) begin
      case (kind)
        WK_ALU:  nxt = '{1'b1, rs_addr, alu_out};
        WK_LINK: nxt = '{1'b1, RADDR_W'(LINK_REG), ra};
        WK_LOAD: push = 1'b1;
        default: nxt = '0;
      endcase
    end
    // r0 writes vanish here; the queue itself still tracks the r0 load.
    if (ZERO_WIRED != 0 && nxt.addr == '0) nxt = '0;
  end

  pend_queue #(
    .DEPTH (PEND_DEPTH),
    .AW    (RADDR_W)
  ) u_pend_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (rs_addr),
    .pop       (pop),
    .head_addr (head_addr),
    .count     (pend_count),
    .chk_addr  (chk_addr),
    .chk_match (q_match)
  );

  assign chk_pending = q_match && !(ZERO_WIRED != 0 && chk_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write     <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      underflow_err <= 1'b0;
    end else begin
      reg_write <= nxt.en;
      wr_addr   <= nxt.addr;
      wr_data   <= nxt.data;
      if (mem_rvalid && q_empty) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: table of single-cycle decode vectors
// plus hand-written load ordering, full-queue, error and reset sequences.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic [4:0]  rs_addr;
  logic [31:0] alu_out;
  logic [31:0] ra;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  chk_addr;
  logic        chk_pending;
  logic [2:0]  pend_count;
  logic        underflow_err;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_commit_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .fcode         (fcode),
    .rs_addr       (rs_addr),
    .alu_out       (alu_out),
    .ra            (ra),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .reg_write     (reg_write),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .chk_addr      (chk_addr),
    .chk_pending   (chk_pending),
    .pend_count    (pend_count),
    .underflow_err (underflow_err)
  );

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [3:0]  fc;
    logic [4:0]  rs;
    logic [31:0] alu;
    logic [31:0] ra;
    logic        we;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_wr(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk(name, {26'd0, reg_write, wr_addr, wr_data}, {26'd0, we, a, d});
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] fc,
                       input logic [4:0] rs, input logic [31:0] alu, input logic [31:0] r);
    in_valid = v; opcode = op; fcode = fc; rs_addr = rs; alu_out = alu; ra = r;
  endtask

  task automatic ret(input logic v, input logic [31:0] d);
    mem_rvalid = v; mem_rdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 3'd0, 4'd0, 5'd0, 32'd0, 32'd0);
    ret(1'b0, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd0, 4'd0, 5'd7,  32'hDEADBEEF, 32'h0,   1'b1, 5'd7,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 3'd1, 4'd3, 5'd12, 32'h00001234, 32'h0,   1'b1, 5'd12, 32'h00001234};
    vecs[2] = '{1'b1, 3'd3, 4'd9, 5'd2,  32'h0000AAAA, 32'h104, 1'b1, 5'd31, 32'h00000104};
    vecs[3] = '{1'b1, 3'd3, 4'd8, 5'd2,  32'h0000AAAA, 32'h104, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 3'd2, 4'd1, 5'd4,  32'h0000BBBB, 32'h0,   1'b0, 5'd0,  32'h0};
    vecs[5] = '{1'b1, 3'd4, 4'd0, 5'd6,  32'h0000CCCC, 32'h0,   1'b0, 5'd0,  32'h0};
    vecs[6] = '{1'b1, 3'd7, 4'd9, 5'd6,  32'h0000CCCC, 32'h8,   1'b0, 5'd0,  32'h0};
    vecs[7] = '{1'b1, 3'd0, 4'd0, 5'd0,  32'h00000055, 32'h0,   1'b0, 5'd0,  32'h0};
    vecs[8] = '{1'b0, 3'd0, 4'd0, 5'd8,  32'h00000066, 32'h0,   1'b0, 5'd0,  32'h0};
    vecs[9] = '{1'b1, 3'd0, 4'd0, 5'd31, 32'hFFFFFFFF, 32'h0,   1'b1, 5'd31, 32'hFFFFFFFF};

    chk_addr = 5'd0;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_wr("reset_wr", 1'b0, 5'd0, 32'd0);
    chk("reset_count", 64'(pend_count), 64'd0);
    chk("reset_uflow", 64'(underflow_err), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);

    // Single-cycle decode table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].fc, vecs[i].rs, vecs[i].alu, vecs[i].ra);
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
      tick();
      chk_wr($sformatf("vec%0d_wr", i), vecs[i].we, vecs[i].ea, vecs[i].ed);
    end
    idle(); tick();
    chk("vec_count", 64'(pend_count), 64'd0);

    // Loads r3, r5, ALU r9, then in-order returns
    drive(1'b1, 3'd2, 4'd0, 5'd3, 32'h0, 32'h0); tick();
    chk_wr("ld3_nowr", 1'b0, 5'd0, 32'd0);
    chk("ld3_count", 64'(pend_count), 64'd1);
    drive(1'b1, 3'd2, 4'd0, 5'd5, 32'h0, 32'h0); tick();
    chk("ld5_count", 64'(pend_count), 64'd2);
    chk_addr = 5'd5; #1;
    chk("pend5_a", 64'(chk_pending), 64'd1);
    chk_addr = 5'd3; #1;
    chk("pend3_a", 64'(chk_pending), 64'd1);
    chk_addr = 5'd9; #1;
    chk("pend9_a", 64'(chk_pending), 64'd0);
    drive(1'b1, 3'd0, 4'd0, 5'd9, 32'h99, 32'h0); tick();
    chk_wr("alu9_wr", 1'b1, 5'd9, 32'h99);
    idle(); ret(1'b1, 32'h11); #1;
    chk("ret3_ready", 64'(in_ready), 64'd0);
    tick();
    chk_wr("ret3_wr", 1'b1, 5'd3, 32'h11);
    chk("ret3_count", 64'(pend_count), 64'd1);
    chk_addr = 5'd5; #1;
    chk("pend5_b", 64'(chk_pending), 64'd1);
    chk_addr = 5'd3; #1;
    chk("pend3_b", 64'(chk_pending), 64'd0);
    ret(1'b1, 32'h22); tick();
    chk_wr("ret5_wr", 1'b1, 5'd5, 32'h22);
    chk("ret5_count", 64'(pend_count), 64'd0);
    chk_addr = 5'd5; #1;
    chk("pend5_c", 64'(chk_pending), 64'd0);
    idle(); tick();
    chk_wr("seqA_idle", 1'b0, 5'd0, 32'd0);

    // Fill the queue, then a return collides with a waiting ALU op
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'd2, 4'd0, 5'(i), 32'h0, 32'h0); tick();
    end
    drive(1'b1, 3'd0, 4'd0, 5'd10, 32'hAA, 32'h0); #1;
    chk("full_count", 64'(pend_count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    tick();
    chk_wr("full_stall", 1'b0, 5'd0, 32'd0);
    chk("full_count2", 64'(pend_count), 64'd4);
    ret(1'b1, 32'h31); #1;
    chk("conf_ready", 64'(in_ready), 64'd0);
    tick();
    chk_wr("conf_ldwr", 1'b1, 5'd1, 32'h31);
    chk("conf_count", 64'(pend_count), 64'd3);
    ret(1'b0, 32'h0); #1;
    chk("conf_ready2", 64'(in_ready), 64'd1);
    tick();
    chk_wr("conf_aluwr", 1'b1, 5'd10, 32'hAA);
    idle();
    for (int i = 2; i <= 4; i++) begin
      ret(1'b1, 32'h30 + 32'(i)); tick();
      chk_wr($sformatf("drain%0d", i), 1'b1, 5'(i), 32'h30 + 32'(i));
    end
    ret(1'b0, 32'h0); #1;
    chk("drain_count", 64'(pend_count), 64'd0);

    // Load to r0, then underflow
    drive(1'b1, 3'd2, 4'd0, 5'd0, 32'h0, 32'h0); tick();
    idle();
    chk("r0_count", 64'(pend_count), 64'd1);
    chk_addr = 5'd0; #1;
    chk("r0_pend", 64'(chk_pending), 64'd0);
    ret(1'b1, 32'h77); tick();
    chk_wr("r0_nowr", 1'b0, 5'd0, 32'd0);
    chk("r0_popped", 64'(pend_count), 64'd0);
    chk("r0_uflow", 64'(underflow_err), 64'd0);
    ret(1'b1, 32'h88); tick();
    chk_wr("uf_nowr", 1'b0, 5'd0, 32'd0);
    chk("uf_set", 64'(underflow_err), 64'd1);
    idle(); tick(); tick();
    chk("uf_sticky", 64'(underflow_err), 64'd1);

    // Reset with two loads pending and a write on the outputs
    drive(1'b1, 3'd2, 4'd0, 5'd6, 32'h0, 32'h0); tick();
    drive(1'b1, 3'd2, 4'd0, 5'd7, 32'h0, 32'h0); tick();
    drive(1'b1, 3'd0, 4'd0, 5'd8, 32'h88, 32'h0); tick();
    chk_wr("pre_rst_wr", 1'b1, 5'd8, 32'h88);
    chk("pre_rst_count", 64'(pend_count), 64'd2);
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    chk_wr("rst_wr", 1'b0, 5'd0, 32'd0);
    chk("rst_count", 64'(pend_count), 64'd0);
    chk("rst_uflow", 64'(underflow_err), 64'd0);
    chk_addr = 5'd7; #1;
    chk("rst_pend7", 64'(chk_pending), 64'd0);
    ret(1'b1, 32'h66); tick();
    chk_wr("late_nowr", 1'b0, 5'd0, 32'd0);
    chk("late_uflow", 64'(underflow_err), 64'd1);
    idle(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
